// File: rtl/bcd_segment_scanner.sv
// Three-digit multiplexed 7-segment scanner with shadowed BCD inputs and a blank gap between slots.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_segment_scanner #(
    parameter int SCAN_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       update,
    input  logic [3:0] d1,
    input  logic [3:0] d10,
    input  logic [3:0] d100,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic [1:0] digit_sel
);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 16'd0 : 16'(BLANK_CYCLES - 1);
    localparam bit          NO_GAP     = (BLANK_CYCLES == 0);

    state_t      state;
    state_t      state_next;
    logic [1:0]  index;
    logic [1:0]  index_next;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [3:0]  sh1;
    logic [3:0]  sh10;
    logic [3:0]  sh100;
    logic [3:0]  digit_next;
    logic        slot_blank;
    logic        lit_next;
    logic [2:0]  an_next;
    logic [6:0]  seg_next;

    function automatic logic [1:0] next_slot(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // The display only ever sees captured values, never the converter mid-count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh1   <= 4'd0;
            sh10  <= 4'd0;
            sh100 <= 4'd0;
        end else if (update) begin
            sh1   <= d1;
            sh10  <= d10;
            sh100 <= d100;
        end
    end

    // The index advances when a slot ends, so the following gap already reports the next slot.
    always_comb begin
        state_next = state;
        index_next = index;
        count_next = count + 16'd1;
        case (state)
            SHOW: begin
                if (count >= SCAN_LAST) begin
                    count_next = 16'd0;
                    index_next = next_slot(index);
                    state_next = NO_GAP ? SHOW : BLANK;
                end
            end
            BLANK: begin
                if (count >= BLANK_LAST) begin
                    count_next = 16'd0;
                    state_next = SHOW;
                end
            end
            default: begin
                count_next = 16'd0;
                state_next = BLANK;
            end
        endcase
    end

    always_comb begin
        digit_next = sh100;
        case (index_next)
            2'd0:    digit_next = sh1;
            2'd1:    digit_next = sh10;
            default: digit_next = sh100;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        slot_blank = 1'b0;
        case (index_next)
            2'd2:    slot_blank = (sh100 == 4'd0);
            2'd1:    slot_blank = (sh100 == 4'd0) && (sh10 == 4'd0);
            default: slot_blank = 1'b0;
        endcase
    end
`else
    assign slot_blank = 1'b0;
`endif

    // Outputs are registered from the upcoming state so anode and segments switch together.
    always_comb begin
        lit_next = (state_next == SHOW) && !slot_blank;
        an_next  = 3'b111;
        seg_next = 7'b1111111;
        if (lit_next) begin
            an_next  = ~(3'b001 << index_next);
            seg_next = decode(digit_next);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            index <= 2'd0;
            count <= 16'd0;
            an    <= 3'b111;
            seg   <= 7'b1111111;
        end else begin
            state <= state_next;
            index <= index_next;
            count <= count_next;
            an    <= an_next;
            seg   <= seg_next;
        end
    end

    assign digit_sel = index;

endmodule

// File: tb/tb_bcd_segment_scanner.sv
// Scoreboard bench for bcd_segment_scanner with SCAN_CYCLES=4, BLANK_CYCLES=2 (18-cycle frame).
module tb_bcd_segment_scanner;

    localparam int SCAN  = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = SCAN + GAP;
    localparam int FRAME = 3 * SLOT;

    logic       clock;
    logic       reset;
    logic       update;
    logic [3:0] d1;
    logic [3:0] d10;
    logic [3:0] d100;
    logic [6:0] seg;
    logic [2:0] an;
    logic [1:0] digit_sel;

    int n_checks;
    int n_fail;
    int t;
    bit sb_on;
    logic [3:0] m1;
    logic [3:0] m10;
    logic [3:0] m100;
    logic [11:0] exp_q[$];

    bcd_segment_scanner #(.SCAN_CYCLES(SCAN), .BLANK_CYCLES(GAP)) dut (
        .clock(clock),
        .reset(reset),
        .update(update),
        .d1(d1),
        .d10(d10),
        .d100(d100),
        .seg(seg),
        .an(an),
        .digit_sel(digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0d", tag, actual, expected, t);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an, seg, digit_sel} for output interval tt after reset release.
    function automatic logic [11:0] expected_at(input int tt);
        int p;
        int k;
        int q;
        logic [1:0] ks;
        logic [3:0] dig;
        logic blank;
        logic [2:0] a;
        logic [6:0] s;
        p = tt % FRAME;
        k = p / SLOT;
        q = p % SLOT;
        ks = k[1:0];
        dig = (k == 0) ? m1 : (k == 1) ? m10 : m100;
        blank = (q < GAP);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 2 && m100 == 4'd0) blank = 1'b1;
        if (k == 1 && m100 == 4'd0 && m10 == 4'd0) blank = 1'b1;
`endif
        a = blank ? 3'b111 : (k == 0) ? 3'b110 : (k == 1) ? 3'b101 : 3'b011;
        s = blank ? 7'b1111111 : seg_of(dig);
        return {a, s, ks};
    endfunction

    always @(posedge clock) begin
        if (sb_on) begin
            t++;
            exp_q.push_back(expected_at(t));
            if (update) begin
                m1   = d1;
                m10  = d10;
                m100 = d100;
            end
        end
    end

    always @(negedge clock) begin
        if (sb_on) begin
            check_output("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_output("scan", 32'({an, seg, digit_sel}), 32'(exp_q.pop_front()));
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        sb_on = 1'b0;
        exp_q.delete();
        m1 = 4'd0;
        m10 = 4'd0;
        m100 = 4'd0;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        t = 0;
        exp_q.push_back(expected_at(0));
        sb_on = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [3:0] v100, input logic [3:0] v10, input logic [3:0] v1);
        d100 = v100;
        d10 = v10;
        d1 = v1;
        update = 1'b1;
        @(posedge clock);
        #1;
        update = 1'b0;
    endtask

    task automatic wait_for_pos(input int pos);
        int guard;
        guard = 0;
        while ((t % FRAME) != pos && guard < 2 * FRAME) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check_output("wait_pos", 32'(t % FRAME), 32'(pos));
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        t = 0;
        update = 1'b0;
        d1 = 4'd0;
        d10 = 4'd0;
        d100 = 4'd0;
        enter_reset();
        #2;
        check_output("rst_an", 32'(an), 32'h7);
        check_output("rst_seg", 32'(seg), 32'h7F);
        check_output("rst_sel", 32'(digit_sel), 32'h0);
        run_cycles(3);
        check_output("rst_hold_an", 32'(an), 32'h7);
        check_output("rst_hold_seg", 32'(seg), 32'h7F);

        release_reset();
        run_cycles(2 * FRAME);

        apply_stimulus(4'd1, 4'd2, 4'd3);
        run_cycles(FRAME + 2);

        for (int v = 0; v < 10; v++) begin
            d1 = 4'(v);
            @(posedge clock);
            #1;
        end
        wait_for_pos(GAP + 1);
        d1 = 4'd7;
        apply_stimulus(d100, d10, 4'd7);
        run_cycles(FRAME);

        apply_stimulus(4'd1, 4'hC, 4'd3);
        run_cycles(FRAME + 2);

        apply_stimulus(4'd0, 4'd0, 4'd7);
        run_cycles(FRAME + 2);
        apply_stimulus(4'd0, 4'd5, 4'd0);
        run_cycles(FRAME + 2);

        d100 = 4'd4;
        d10 = 4'd5;
        d1 = 4'd6;
        update = 1'b1;
        @(posedge clock);
        #1;
        apply_stimulus(4'd8, 4'd9, 4'd1);
        run_cycles(FRAME + 2);

        wait_for_pos(GAP + 1);
        enter_reset();
        #1;
        check_output("midrst_an", 32'(an), 32'h7);
        check_output("midrst_seg", 32'(seg), 32'h7F);
        check_output("midrst_sel", 32'(digit_sel), 32'h0);
        run_cycles(2);
        release_reset();
        run_cycles(FRAME + 4);

        sb_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
